// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station slice.
// Contents: operand/op/tag widths, default sizing, op codes and the
// per-entry storage record.
package reservation_station_pkg;

  localparam int unsigned OP_SIZE_LOG         = 5;
  localparam int unsigned ROB_SIZE_LOG        = 4;
  localparam int unsigned RS_SIZE_DEFAULT     = 16;
  localparam int unsigned RS_SIZE_LOG_DEFAULT = 4;

  typedef enum logic [OP_SIZE_LOG-1:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_ADDI, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
  } op_e;

  typedef struct packed {
    logic                    valid;
    logic [OP_SIZE_LOG-1:0]  op;
    logic [31:0]             vj;
    logic [31:0]             vk;
    logic [ROB_SIZE_LOG-1:0] qj;
    logic [ROB_SIZE_LOG-1:0] qk;
    logic                    rj;
    logic                    rk;
    logic [31:0]             imm;
    logic [31:0]             pc;
    logic [ROB_SIZE_LOG-1:0] robid;
  } rs_entry_t;

endpackage

// File: rtl/reservation_station_select.sv
// Priority picker used by the reservation station, both for the dispatch
// choice and for the lowest-free-slot search.
// Picks the requesting entry with the largest age; ties (including an
// all-zero age vector) go to the lowest index.
// Ports:
//   i_req   [N]     request vector
//   i_age   [N][W]  per-entry age (tie to '0 for plain lowest-index)
//   o_found         at least one request
//   o_idx   [W]     selected index (0 when none)
module rs_select
  import reservation_station_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic [N-1:0]        i_req,
  input  logic [N-1:0][W-1:0] i_age,
  output logic                o_found,
  output logic [W-1:0]        o_idx
);

  logic [W-1:0] w_best_age;

  always_comb begin
    o_found    = 1'b0;
    o_idx      = '0;
    w_best_age = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // Strictly greater keeps the earlier (lower) index on a tie.
      if (i_req[i] && (!o_found || (i_age[i] > w_best_age))) begin
        o_found    = 1'b1;
        o_idx      = W'(i);
        w_best_age = i_age[i];
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for non-memory ops: accepts renamed ops from issue,
// wakes waiting operands from the ALU and LSB CDBs, and dispatches one
// fully-ready op per cycle to the ALU. Cleared by rob_flush.
// Optional build macro RS_AGE_SELECT_EN: dispatch the oldest ready entry
// (saturating per-entry age); otherwise dispatch the lowest-index ready entry.
// Ports:
//   clk, rst, rdy                      clock, sync active-high reset, global enable
//   rs_send_enable, op_type, vj, vk,   issue strobe and renamed op
//   qj, qk, rj, rk, imm, pc, send_robid
//   rs_full                            no free entry (combinational)
//   alu_cdb_*, lsb_cdb_*               broadcast buses
//   rob_flush                          misprediction clear
//   alu_en, alu_op, alu_vj, alu_vk,    registered dispatch to the ALU
//   alu_imm, alu_pc, alu_robid
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE     = RS_SIZE_DEFAULT,
  parameter int unsigned RS_SIZE_LOG = RS_SIZE_LOG_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rs_send_enable,
  input  logic [OP_SIZE_LOG-1:0]  op_type,
  input  logic [31:0]             vj,
  input  logic [31:0]             vk,
  input  logic [ROB_SIZE_LOG-1:0] qj,
  input  logic [ROB_SIZE_LOG-1:0] qk,
  input  logic                    rj,
  input  logic                    rk,
  input  logic [31:0]             imm,
  input  logic [31:0]             pc,
  input  logic [ROB_SIZE_LOG-1:0] send_robid,
  output logic                    rs_full,
  input  logic                    alu_cdb_valid,
  input  logic [ROB_SIZE_LOG-1:0] alu_cdb_robid,
  input  logic [31:0]             alu_cdb_value,
  input  logic                    lsb_cdb_valid,
  input  logic [ROB_SIZE_LOG-1:0] lsb_cdb_robid,
  input  logic [31:0]             lsb_cdb_value,
  input  logic                    rob_flush,
  output logic                    alu_en,
  output logic [OP_SIZE_LOG-1:0]  alu_op,
  output logic [31:0]             alu_vj,
  output logic [31:0]             alu_vk,
  output logic [31:0]             alu_imm,
  output logic [31:0]             alu_pc,
  output logic [ROB_SIZE_LOG-1:0] alu_robid
);

  rs_entry_t r_ent [RS_SIZE];

  logic [RS_SIZE-1:0]                  w_valid;
  logic [RS_SIZE-1:0]                  w_ready;
  logic [RS_SIZE-1:0][RS_SIZE_LOG-1:0] w_disp_age;
  logic                                w_free_found;
  logic [RS_SIZE_LOG-1:0]              w_free_idx;
  logic                                w_disp_found;
  logic [RS_SIZE_LOG-1:0]              w_disp_idx;
  logic                                w_do_issue;
  rs_entry_t                           w_new;

  // Start-of-cycle views: entries written this cycle are not visible to
  // either the free search or the dispatch choice until the next edge.
  always_comb begin
    w_valid = '0;
    w_ready = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_ready[i] = r_ent[i].valid && r_ent[i].rj && r_ent[i].rk;
    end
  end

  assign rs_full    = &w_valid;
  assign w_do_issue = rs_send_enable && w_free_found;

  rs_select #(.N(RS_SIZE), .W(RS_SIZE_LOG)) u_free_sel (
    .i_req   (~w_valid),
    .i_age   ('0),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  rs_select #(.N(RS_SIZE), .W(RS_SIZE_LOG)) u_disp_sel (
    .i_req   (w_ready),
    .i_age   (w_disp_age),
    .o_found (w_disp_found),
    .o_idx   (w_disp_idx)
  );

  // Incoming op with same-cycle CDB bypass on unresolved operands.
  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.op    = op_type;
    w_new.vj    = vj;
    w_new.vk    = vk;
    w_new.qj    = qj;
    w_new.qk    = qk;
    w_new.rj    = rj;
    w_new.rk    = rk;
    w_new.imm   = imm;
    w_new.pc    = pc;
    w_new.robid = send_robid;
    if (!rj) begin
      if (alu_cdb_valid && (qj == alu_cdb_robid)) begin
        w_new.rj = 1'b1;
        w_new.vj = alu_cdb_value;
      end else if (lsb_cdb_valid && (qj == lsb_cdb_robid)) begin
        w_new.rj = 1'b1;
        w_new.vj = lsb_cdb_value;
      end
    end
    if (!rk) begin
      if (alu_cdb_valid && (qk == alu_cdb_robid)) begin
        w_new.rk = 1'b1;
        w_new.vk = alu_cdb_value;
      end else if (lsb_cdb_valid && (qk == lsb_cdb_robid)) begin
        w_new.rk = 1'b1;
        w_new.vk = lsb_cdb_value;
      end
    end
  end

`ifdef RS_AGE_SELECT_EN
  logic [RS_SIZE-1:0][RS_SIZE_LOG-1:0] r_age;

  assign w_disp_age = r_age;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= '0;
    end else if (rdy && !rob_flush) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (w_do_issue && (w_free_idx == RS_SIZE_LOG'(i))) begin
          r_age[i] <= '0;
        end else if (r_ent[i].valid && (r_age[i] != '1)) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end
`else
  assign w_disp_age = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        r_ent[i] <= '0;
      end
      alu_en    <= 1'b0;
      alu_op    <= '0;
      alu_vj    <= '0;
      alu_vk    <= '0;
      alu_imm   <= '0;
      alu_pc    <= '0;
      alu_robid <= '0;
    end else if (!rdy) begin
      alu_en <= 1'b0;
    end else if (rob_flush) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        r_ent[i].valid <= 1'b0;
      end
      alu_en <= 1'b0;
    end else begin
      // Wakeup touches only waiting operands of valid entries, so it never
      // collides with the dispatched (already ready) or the newly issued slot.
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (r_ent[i].valid && !r_ent[i].rj) begin
          if (alu_cdb_valid && (r_ent[i].qj == alu_cdb_robid)) begin
            r_ent[i].rj <= 1'b1;
            r_ent[i].vj <= alu_cdb_value;
          end else if (lsb_cdb_valid && (r_ent[i].qj == lsb_cdb_robid)) begin
            r_ent[i].rj <= 1'b1;
            r_ent[i].vj <= lsb_cdb_value;
          end
        end
        if (r_ent[i].valid && !r_ent[i].rk) begin
          if (alu_cdb_valid && (r_ent[i].qk == alu_cdb_robid)) begin
            r_ent[i].rk <= 1'b1;
            r_ent[i].vk <= alu_cdb_value;
          end else if (lsb_cdb_valid && (r_ent[i].qk == lsb_cdb_robid)) begin
            r_ent[i].rk <= 1'b1;
            r_ent[i].vk <= lsb_cdb_value;
          end
        end
      end

      if (w_disp_found) begin
        alu_en                 <= 1'b1;
        alu_op                 <= r_ent[w_disp_idx].op;
        alu_vj                 <= r_ent[w_disp_idx].vj;
        alu_vk                 <= r_ent[w_disp_idx].vk;
        alu_imm                <= r_ent[w_disp_idx].imm;
        alu_pc                 <= r_ent[w_disp_idx].pc;
        alu_robid              <= r_ent[w_disp_idx].robid;
        r_ent[w_disp_idx].valid <= 1'b0;
      end else begin
        alu_en <= 1'b0;
      end

      if (w_do_issue) begin
        r_ent[w_free_idx] <= w_new;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    rdy;
  logic                    rs_send_enable;
  logic [OP_SIZE_LOG-1:0]  op_type;
  logic [31:0]             vj, vk, imm, pc;
  logic [ROB_SIZE_LOG-1:0] qj, qk, send_robid;
  logic                    rj, rk;
  logic                    rs_full;
  logic                    alu_cdb_valid, lsb_cdb_valid;
  logic [ROB_SIZE_LOG-1:0] alu_cdb_robid, lsb_cdb_robid;
  logic [31:0]             alu_cdb_value, lsb_cdb_value;
  logic                    rob_flush;
  logic                    alu_en;
  logic [OP_SIZE_LOG-1:0]  alu_op;
  logic [31:0]             alu_vj, alu_vk, alu_imm, alu_pc;
  logic [ROB_SIZE_LOG-1:0] alu_robid;

  int total;
  int bad;

  reservation_station #(.RS_SIZE(16), .RS_SIZE_LOG(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rs_send_enable(rs_send_enable),
    .op_type(op_type), .vj(vj), .vk(vk), .qj(qj), .qk(qk), .rj(rj), .rk(rk),
    .imm(imm), .pc(pc), .send_robid(send_robid), .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_robid(alu_cdb_robid),
    .alu_cdb_value(alu_cdb_value), .lsb_cdb_valid(lsb_cdb_valid),
    .lsb_cdb_robid(lsb_cdb_robid), .lsb_cdb_value(lsb_cdb_value),
    .rob_flush(rob_flush), .alu_en(alu_en), .alu_op(alu_op),
    .alu_vj(alu_vj), .alu_vk(alu_vk), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_robid(alu_robid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model (slot-level, from the op rules) -----
  logic                    m_v   [16];
  logic [OP_SIZE_LOG-1:0]  m_op  [16];
  logic [31:0]             m_vj  [16], m_vk [16], m_imm [16], m_pc [16];
  logic [ROB_SIZE_LOG-1:0] m_qj  [16], m_qk [16], m_rob [16];
  logic                    m_rj  [16], m_rk [16];
  int                      m_t   [16];
  int                      m_cyc;
  logic                    e_en;
  logic [OP_SIZE_LOG-1:0]  e_op;
  logic [31:0]             e_vj, e_vk, e_imm, e_pc;
  logic [ROB_SIZE_LOG-1:0] e_rob;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
    m_cyc = 0;
    e_en = 1'b0; e_op = '0; e_vj = '0; e_vk = '0; e_imm = '0; e_pc = '0; e_rob = '0;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 16; i++) if (m_v[i]) n++;
    return n;
  endfunction

  // Applies one clock edge to the model using the current TB input values.
  task automatic model_edge();
    int best, best_age, fs, age;
    if (!rdy) begin
      e_en = 1'b0;
      return;
    end
    if (rob_flush) begin
      for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
      e_en = 1'b0;
      m_cyc++;
      return;
    end
    best = -1; best_age = -1; fs = -1;
    for (int i = 0; i < 16; i++) begin
      if (m_v[i] && m_rj[i] && m_rk[i]) begin
`ifdef RS_AGE_SELECT_EN
        age = m_cyc - m_t[i] - 1;
        if (age > 15) age = 15;
`else
        age = 0;
`endif
        if (age > best_age) begin best = i; best_age = age; end
      end
      if (!m_v[i] && fs < 0) fs = i;
    end
    for (int i = 0; i < 16; i++) begin
      if (m_v[i] && !m_rj[i]) begin
        if (alu_cdb_valid && m_qj[i] == alu_cdb_robid) begin m_rj[i] = 1'b1; m_vj[i] = alu_cdb_value; end
        else if (lsb_cdb_valid && m_qj[i] == lsb_cdb_robid) begin m_rj[i] = 1'b1; m_vj[i] = lsb_cdb_value; end
      end
      if (m_v[i] && !m_rk[i]) begin
        if (alu_cdb_valid && m_qk[i] == alu_cdb_robid) begin m_rk[i] = 1'b1; m_vk[i] = alu_cdb_value; end
        else if (lsb_cdb_valid && m_qk[i] == lsb_cdb_robid) begin m_rk[i] = 1'b1; m_vk[i] = lsb_cdb_value; end
      end
    end
    if (best >= 0) begin
      e_en = 1'b1; e_op = m_op[best]; e_vj = m_vj[best]; e_vk = m_vk[best];
      e_imm = m_imm[best]; e_pc = m_pc[best]; e_rob = m_rob[best];
      m_v[best] = 1'b0;
    end else begin
      e_en = 1'b0;
    end
    if (rs_send_enable && fs >= 0) begin
      m_v[fs] = 1'b1; m_op[fs] = op_type; m_imm[fs] = imm; m_pc[fs] = pc; m_rob[fs] = send_robid;
      m_qj[fs] = qj; m_qk[fs] = qk; m_rj[fs] = rj; m_rk[fs] = rk; m_vj[fs] = vj; m_vk[fs] = vk;
      if (!rj && alu_cdb_valid && qj == alu_cdb_robid) begin m_rj[fs] = 1'b1; m_vj[fs] = alu_cdb_value; end
      else if (!rj && lsb_cdb_valid && qj == lsb_cdb_robid) begin m_rj[fs] = 1'b1; m_vj[fs] = lsb_cdb_value; end
      if (!rk && alu_cdb_valid && qk == alu_cdb_robid) begin m_rk[fs] = 1'b1; m_vk[fs] = alu_cdb_value; end
      else if (!rk && lsb_cdb_valid && qk == lsb_cdb_robid) begin m_rk[fs] = 1'b1; m_vk[fs] = lsb_cdb_value; end
      m_t[fs] = m_cyc;
    end
    m_cyc++;
  endtask

  // ---------------- stimulus helpers ------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rdy = 1'b1; rs_send_enable = 1'b0; op_type = '0; vj = '0; vk = '0;
    qj = '0; qk = '0; rj = 1'b0; rk = 1'b0; imm = '0; pc = '0; send_robid = '0;
    alu_cdb_valid = 1'b0; alu_cdb_robid = '0; alu_cdb_value = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_robid = '0; lsb_cdb_value = '0;
    rob_flush = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_issue(input logic [OP_SIZE_LOG-1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [ROB_SIZE_LOG-1:0] ta, input logic [ROB_SIZE_LOG-1:0] tb,
                           input logic ra, input logic rb, input logic [ROB_SIZE_LOG-1:0] rob);
    rs_send_enable = 1'b1; op_type = o; vj = a; vk = b; qj = ta; qk = tb;
    rj = ra; rk = rb; imm = 32'h100 + 32'(rob); pc = 32'h4000 + 32'(rob); send_robid = rob;
  endtask

  // ---------------- tests -----------------------------------------------
  task automatic test_reset();
    do_reset();
    total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL reset_alu_en got=%0d exp=0", alu_en); end
    total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL reset_rs_full got=%0d exp=0", rs_full); end
    total++; if ({alu_op, alu_vj, alu_vk, alu_imm, alu_pc, alu_robid} !== '0) begin
      bad++; $display("FAIL reset_alu_fields got=%h/%h/%h exp=0", alu_vj, alu_vk, alu_robid);
    end
  endtask

  task automatic test_issue_ready();
    do_reset();
    set_issue(OP_ADD, 32'd5, 32'd7, '0, '0, 1'b1, 1'b1, 4'd3);
    tick();
    clear_inputs();
    total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL issue_not_same_cycle got=%0d exp=0", alu_en); end
    tick();
    total++; if (alu_en !== 1'b1) begin bad++; $display("FAIL issue_alu_en got=%0d exp=1", alu_en); end
    total++; if (alu_vj !== 32'd5 || alu_vk !== 32'd7) begin bad++; $display("FAIL issue_operands got=%0d,%0d exp=5,7", alu_vj, alu_vk); end
    total++; if (alu_robid !== 4'd3 || alu_op !== OP_ADD) begin bad++; $display("FAIL issue_robid_op got=%0d,%0d exp=3,%0d", alu_robid, alu_op, OP_ADD); end
    total++; if (alu_imm !== 32'h103 || alu_pc !== 32'h4003) begin bad++; $display("FAIL issue_imm_pc got=%h,%h exp=103,4003", alu_imm, alu_pc); end
    tick();
    total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL issue_entry_freed got=%0d exp=0", alu_en); end
  endtask

  task automatic test_cdb_wakeup();
    do_reset();
    set_issue(OP_SUB, 32'd0, 32'd2, 4'd4, '0, 1'b0, 1'b1, 4'd1);
    tick();
    clear_inputs();
    tick();
    total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL wake_waiting got=%0d exp=0", alu_en); end
    alu_cdb_valid = 1'b1; alu_cdb_robid = 4'd4; alu_cdb_value = 32'h10;
    tick();
    clear_inputs();
    total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL wake_not_same_cycle got=%0d exp=0", alu_en); end
    tick();
    total++; if (alu_en !== 1'b1 || alu_vj !== 32'h10) begin bad++; $display("FAIL wake_dispatch got=en%0d vj=%h exp=en1 vj=10", alu_en, alu_vj); end
  endtask

  task automatic test_bypass();
    do_reset();
    set_issue(OP_AND, 32'd9, 32'd0, '0, 4'd6, 1'b1, 1'b0, 4'd2);
    lsb_cdb_valid = 1'b1; lsb_cdb_robid = 4'd6; lsb_cdb_value = 32'hAB;
    tick();
    clear_inputs();
    tick();
    total++; if (alu_en !== 1'b1 || alu_vk !== 32'hAB) begin bad++; $display("FAIL bypass got=en%0d vk=%h exp=en1 vk=ab", alu_en, alu_vk); end
  endtask

  task automatic test_full();
    int n_disp, next_vk;
    logic seen_dead;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_issue(OP_OR, 32'd0, 32'(i), (i == 0) ? 4'd8 : 4'd9, '0, 1'b0, 1'b1, 4'(i));
      tick();
      total++; if (rs_full !== (i == 15)) begin bad++; $display("FAIL full_fill_%0d got=%0d exp=%0d", i, rs_full, (i == 15)); end
    end
    set_issue(OP_XOR, 32'd1, 32'hDEAD, '0, '0, 1'b1, 1'b1, 4'd0);
    tick();
    clear_inputs();
    total++; if (rs_full !== 1'b1 || alu_en !== 1'b0) begin bad++; $display("FAIL full_drop got=full%0d en%0d exp=full1 en0", rs_full, alu_en); end
    alu_cdb_valid = 1'b1; alu_cdb_robid = 4'd8; alu_cdb_value = 32'h55;
    tick();
    clear_inputs();
    total++; if (rs_full !== 1'b1) begin bad++; $display("FAIL full_after_wake got=%0d exp=1", rs_full); end
    // Strobe into the slot being freed by this cycle's dispatch: must drop.
    set_issue(OP_XOR, 32'd1, 32'hDEAD, '0, '0, 1'b1, 1'b1, 4'd0);
    tick();
    clear_inputs();
    total++; if (alu_en !== 1'b1 || alu_robid !== 4'd0 || alu_vj !== 32'h55) begin
      bad++; $display("FAIL full_dispatch got=en%0d rob%0d vj=%h exp=en1 rob0 vj=55", alu_en, alu_robid, alu_vj);
    end
    total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL full_freed got=%0d exp=0", rs_full); end
    lsb_cdb_valid = 1'b1; lsb_cdb_robid = 4'd9; lsb_cdb_value = 32'h77;
    tick();
    clear_inputs();
    n_disp = 0; next_vk = 1; seen_dead = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (alu_en) begin
        n_disp++;
        if (alu_vk == 32'hDEAD) seen_dead = 1'b1;
        total++; if (alu_vk !== 32'(next_vk)) begin bad++; $display("FAIL full_drain_order got=%0d exp=%0d", alu_vk, next_vk); end
        next_vk++;
      end
    end
    total++; if (n_disp !== 15) begin bad++; $display("FAIL full_drain_count got=%0d exp=15", n_disp); end
    total++; if (seen_dead !== 1'b0) begin bad++; $display("FAIL full_dropped_op_dispatched got=1 exp=0"); end
  endtask

  task automatic test_flush();
    int n_disp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_issue(OP_ADD, 32'd0, 32'd1, 4'd2, '0, 1'b0, 1'b1, 4'(i));
      tick();
    end
    clear_inputs();
    rob_flush = 1'b1;
    set_issue(OP_ADD, 32'd3, 32'd4, '0, '0, 1'b1, 1'b1, 4'd9);
    alu_cdb_valid = 1'b1; alu_cdb_robid = 4'd2; alu_cdb_value = 32'h1;
    tick();
    clear_inputs();
    total++; if (alu_en !== 1'b0 || rs_full !== 1'b0) begin bad++; $display("FAIL flush_clear got=en%0d full%0d exp=en0 full0", alu_en, rs_full); end
    alu_cdb_valid = 1'b1; alu_cdb_robid = 4'd2; alu_cdb_value = 32'h1;
    tick();
    clear_inputs();
    n_disp = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (alu_en) n_disp++;
    end
    total++; if (n_disp !== 0) begin bad++; $display("FAIL flush_no_dispatch got=%0d exp=0", n_disp); end
    set_issue(OP_ADD, 32'd3, 32'd4, '0, '0, 1'b1, 1'b1, 4'd7);
    tick();
    clear_inputs();
    rob_flush = 1'b1;
    tick();
    clear_inputs();
    total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL flush_in_dispatch got=%0d exp=0", alu_en); end
    tick();
    total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL flush_entry_gone got=%0d exp=0", alu_en); end
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    set_issue(OP_SLT, 32'h11, 32'h22, '0, '0, 1'b1, 1'b1, 4'd4);
    tick();
    clear_inputs();
    rdy = 1'b0;
    tick();
    total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL freeze_1 got=%0d exp=0", alu_en); end
    tick();
    total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL freeze_2 got=%0d exp=0", alu_en); end
    rdy = 1'b1;
    tick();
    total++; if (alu_en !== 1'b1 || alu_robid !== 4'd4 || alu_vj !== 32'h11) begin
      bad++; $display("FAIL freeze_resume got=en%0d rob%0d exp=en1 rob4", alu_en, alu_robid);
    end
  endtask

  task automatic test_age_order();
    logic [3:0] first, second;
`ifdef RS_AGE_SELECT_EN
    first = 4'd12; second = 4'd13;
`else
    first = 4'd13; second = 4'd12;
`endif
    do_reset();
    set_issue(OP_ADD, 32'd0, 32'd0, 4'd1, '0, 1'b0, 1'b1, 4'd10);  // slot 0
    tick();
    set_issue(OP_ADD, 32'd0, 32'd0, 4'd7, '0, 1'b0, 1'b1, 4'd11);  // slot 1
    tick();
    set_issue(OP_ADD, 32'd0, 32'd0, 4'd5, '0, 1'b0, 1'b1, 4'd12);  // slot 2
    tick();
    clear_inputs();
    alu_cdb_valid = 1'b1; alu_cdb_robid = 4'd1; alu_cdb_value = 32'h1;
    tick();
    clear_inputs();
    tick();
    total++; if (alu_en !== 1'b1 || alu_robid !== 4'd10) begin bad++; $display("FAIL age_free_slot0 got=en%0d rob%0d exp=en1 rob10", alu_en, alu_robid); end
    set_issue(OP_ADD, 32'd0, 32'd0, 4'd5, '0, 1'b0, 1'b1, 4'd13);  // reuses slot 0
    tick();
    clear_inputs();
    tick();
    tick();
    tick();
    lsb_cdb_valid = 1'b1; lsb_cdb_robid = 4'd5; lsb_cdb_value = 32'h99;
    tick();
    clear_inputs();
    tick();
    total++; if (alu_en !== 1'b1 || alu_robid !== first) begin bad++; $display("FAIL age_first got=en%0d rob%0d exp=en1 rob%0d", alu_en, alu_robid, first); end
    tick();
    total++; if (alu_en !== 1'b1 || alu_robid !== second) begin bad++; $display("FAIL age_second got=en%0d rob%0d exp=en1 rob%0d", alu_en, alu_robid, second); end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      rdy            = ($urandom_range(0, 9) != 0);
      rob_flush      = ($urandom_range(0, 59) == 0);
      rs_send_enable = ($urandom_range(0, 9) < 6);
      op_type        = OP_SIZE_LOG'($urandom_range(0, 21));
      vj = $urandom; vk = $urandom; imm = $urandom; pc = $urandom;
      qj = ROB_SIZE_LOG'($urandom); qk = ROB_SIZE_LOG'($urandom);
      rj = ($urandom_range(0, 2) == 0); rk = ($urandom_range(0, 2) == 0);
      send_robid = ROB_SIZE_LOG'($urandom);
      alu_cdb_valid = ($urandom_range(0, 2) == 0);
      alu_cdb_robid = ROB_SIZE_LOG'($urandom); alu_cdb_value = $urandom;
      lsb_cdb_valid = ($urandom_range(0, 3) == 0);
      lsb_cdb_robid = ROB_SIZE_LOG'($urandom); lsb_cdb_value = $urandom;
      if (alu_cdb_valid && lsb_cdb_valid && alu_cdb_robid == lsb_cdb_robid) lsb_cdb_robid = lsb_cdb_robid + 1'b1;
      model_edge();
      tick();
      total++; if (alu_en !== e_en) begin bad++; $display("FAIL rand_alu_en cyc=%0d got=%0d exp=%0d", c, alu_en, e_en); end
      total++; if (rs_full !== (model_count() == 16)) begin bad++; $display("FAIL rand_rs_full cyc=%0d got=%0d exp=%0d", c, rs_full, model_count() == 16); end
      if (e_en) begin
        total++; if ({alu_op, alu_robid} !== {e_op, e_rob}) begin bad++; $display("FAIL rand_op_rob cyc=%0d got=%0d/%0d exp=%0d/%0d", c, alu_op, alu_robid, e_op, e_rob); end
        total++; if ({alu_vj, alu_vk} !== {e_vj, e_vk}) begin bad++; $display("FAIL rand_operands cyc=%0d got=%h/%h exp=%h/%h", c, alu_vj, alu_vk, e_vj, e_vk); end
        total++; if ({alu_imm, alu_pc} !== {e_imm, e_pc}) begin bad++; $display("FAIL rand_imm_pc cyc=%0d got=%h/%h exp=%h/%h", c, alu_imm, alu_pc, e_imm, e_pc); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_inputs();
    test_reset();
    test_issue_ready();
    test_cdb_wakeup();
    test_bypass();
    test_full();
    test_flush();
    test_rdy_freeze();
    test_age_order();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
